// File: rtl/memory_access_stage.sv
// Memory access pipeline stage: issues loads/stores to a handshaked memory,
// passes ALU results to writeback, and stalls upstream while a transaction waits.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   memWe, regWe        store / register-write requests from execute
//   writeRegFromAlu     1 = ALU result to regfile, 0 with regWe = load
//   regToWrite          destination register index
//   dataToWrite         store data
//   result              ALU result, also load/store address
//   stall               upstream holds its inputs while high (combinational)
//   memReq, memWrite    memory request and direction (1 = write)
//   memAddr, memWdata   memory address and write data
//   memRdata, memReady  memory read data and completion
//   regWeOut            writeback enable
//   regToWriteOut       writeback register index
//   wbData              writeback data
//   memError            sticky timeout flag
module memory_access_stage #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memWe,
    input  logic        regWe,
    input  logic        writeRegFromAlu,
    input  logic [3:0]  regToWrite,
    input  logic [23:0] dataToWrite,
    input  logic [23:0] result,
    output logic        stall,
    output logic        memReq,
    output logic        memWrite,
    output logic [23:0] memAddr,
    output logic [23:0] memWdata,
    input  logic [23:0] memRdata,
    input  logic        memReady,
    output logic        regWeOut,
    output logic [3:0]  regToWriteOut,
    output logic [23:0] wbData,
    output logic        memError
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_WAIT = 2'd1,
        READ_WAIT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_write_q, mem_write_d;
    logic [23:0] mem_addr_q, mem_addr_d;
    logic [23:0] mem_wdata_q, mem_wdata_d;
    logic        reg_we_q, reg_we_d;
    logic [3:0]  rd_out_q, rd_out_d;
    logic [23:0] wb_data_q, wb_data_d;
    logic        mem_err_q, mem_err_d;
    logic [3:0]  rd_lat_q, rd_lat_d;
    logic [7:0]  cnt_q, cnt_d;

    logic is_store, is_load, is_alu;

    // memWe wins over regWe, so a store never writes back.
    assign is_store = memWe;
    assign is_load  = !memWe && regWe && !writeRegFromAlu;
    assign is_alu   = !memWe && regWe && writeRegFromAlu;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        reg_we_d    = 1'b0;
        rd_out_d    = rd_out_q;
        wb_data_d   = wb_data_q;
        mem_err_d   = mem_err_q;
        rd_lat_d    = rd_lat_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                unique case (1'b1)
                    is_store: begin
                        state_d     = WRITE_WAIT;
                        mem_req_d   = 1'b1;
                        mem_write_d = 1'b1;
                        mem_addr_d  = result;
                        mem_wdata_d = dataToWrite;
                        cnt_d       = 8'd0;
                    end
                    is_load: begin
                        state_d     = READ_WAIT;
                        mem_req_d   = 1'b1;
                        mem_write_d = 1'b0;
                        mem_addr_d  = result;
                        rd_lat_d    = regToWrite;
                        cnt_d       = 8'd0;
                    end
                    is_alu: begin
                        reg_we_d  = 1'b1;
                        rd_out_d  = regToWrite;
                        wb_data_d = result;
                    end
                    default: ;
                endcase
            end
            WRITE_WAIT, READ_WAIT: begin
                // Completion has priority over a timeout in the same cycle.
                if (memReady) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    cnt_d     = 8'd0;
                    if (state_q == READ_WAIT) begin
                        reg_we_d  = 1'b1;
                        rd_out_d  = rd_lat_q;
                        wb_data_d = memRdata;
                    end
                end else if (cnt_q == TIMEOUT) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_err_d = 1'b1;
                    cnt_d     = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                cnt_d     = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= 24'd0;
            mem_wdata_q <= 24'd0;
            reg_we_q    <= 1'b0;
            rd_out_q    <= 4'd0;
            wb_data_q   <= 24'd0;
            mem_err_q   <= 1'b0;
            rd_lat_q    <= 4'd0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            reg_we_q    <= reg_we_d;
            rd_out_q    <= rd_out_d;
            wb_data_q   <= wb_data_d;
            mem_err_q   <= mem_err_d;
            rd_lat_q    <= rd_lat_d;
            cnt_q       <= cnt_d;
        end
    end

    assign stall         = (state_q != IDLE);
    assign memReq        = mem_req_q;
    assign memWrite      = mem_write_q;
    assign memAddr       = mem_addr_q;
    assign memWdata      = mem_wdata_q;
    assign regWeOut      = reg_we_q;
    assign regToWriteOut = rd_out_q;
    assign wbData        = wb_data_q;
    assign memError      = mem_err_q;

endmodule
